// File: rtl/load_store_unit.sv
// Load/store front-end: decodes RV32 size/sign, drives word-aligned memory accesses, realigns load data.
// Optional LSU_MISALIGN_SPLIT_EN: word-crossing accesses become two memory cycles instead of faulting.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  output logic [3:0]  byte_enable,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [7:0]  r_be;
  logic [63:0] r_wd;
  logic [29:0] r_waddr;
  logic [31:0] r_lo, r_hi;

  logic [2:0]  w_size;
  logic [7:0]  w_mask8, w_be64;
  logic [63:0] w_wd64, w_shift;
  logic [32:0] w_end;
  logic        w_f3_bad, w_range_bad, w_cross, w_err;
  logic [31:0] w_word, w_ext;

  always_comb begin
    case (req_funct3[1:0])
      2'b01:   begin w_size = 3'd2; w_mask8 = 8'h03; end
      2'b10:   begin w_size = 3'd4; w_mask8 = 8'h0F; end
      default: begin w_size = 3'd1; w_mask8 = 8'h01; end
    endcase
  end

  // Loads reject 011/110/111; stores reject everything from 011 upward.
  assign w_f3_bad    = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                              : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
  assign w_be64      = w_mask8 << req_addr[1:0];
  assign w_wd64      = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
  assign w_end       = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
  assign w_range_bad = (w_end >= 33'(MEM_BYTES));
  assign w_cross     = |w_be64[7:4];
`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_err       = w_f3_bad | w_range_bad;
`else
  assign w_err       = w_f3_bad | w_range_bad | w_cross;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_be    <= 8'd0;
      r_wd    <= 64'd0;
      r_waddr <= 30'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_err   <= w_err;
          r_f3    <= req_funct3;
          r_off   <= req_addr[1:0];
          r_be    <= w_be64;
          r_wd    <= w_wd64;
          r_waddr <= req_addr[31:2];
          r_lo    <= 32'd0;
          r_hi    <= 32'd0;
        end
        ACC0: if (!r_we) r_lo <= read_data;
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC1: if (!r_we) r_hi <= read_data;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    addr        = 32'd0;
    write_data  = 32'd0;
    byte_enable = 4'd0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_err ? RESP : ACC0;
      end
      ACC0: begin
        MemRead     = ~r_we;
        MemWrite    = r_we;
        addr        = {r_waddr, 2'b00};
        byte_enable = r_be[3:0];
        write_data  = r_wd[31:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        w_next      = (|r_be[7:4]) ? ACC1 : RESP;
`else
        w_next      = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        MemRead     = ~r_we;
        MemWrite    = r_we;
        addr        = {r_waddr + 30'd1, 2'b00};
        byte_enable = r_be[7:4];
        write_data  = r_wd[63:32];
        w_next      = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_shift = {r_hi, r_lo} >> {r_off, 3'b000};
  assign w_word  = w_shift[31:0];

  always_comb begin
    case (r_f3)
      3'b000:  w_ext = {{24{w_word[7]}}, w_word[7:0]};
      3'b001:  w_ext = {{16{w_word[15]}}, w_word[15:0]};
      3'b100:  w_ext = {24'd0, w_word[7:0]};
      3'b101:  w_ext = {16'd0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  assign resp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_ext : 32'd0;
  assign resp_err   = (r_state == RESP) & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a byte-addressed memory model behind it.
// Expectations for word-crossing accesses follow LSU_MISALIGN_SPLIT_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] addr, write_data, read_data;
  logic [3:0]  byte_enable;

  int tests = 0;
  int fails = 0;

  logic [32:0] sb_q[$];
  string       nm_q[$];

  logic [7:0]  mem [0:4095];
  logic [11:0] ba;

  logic [31:0] acc_addr[4];
  logic [31:0] acc_wd[4];
  logic [3:0]  acc_be[4];
  int          n_acc;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .write_data(write_data), .byte_enable(byte_enable), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign ba        = {addr[11:2], 2'b00};
  assign read_data = {mem[ba + 12'd3], mem[ba + 12'd2], mem[ba + 12'd1], mem[ba]};

  always @(posedge clk) begin
    if (MemWrite) begin
      for (int b = 0; b < 4; b++)
        if (byte_enable[b]) mem[ba + 12'(b)] <= write_data[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever one is handed over.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got rdata 0x%08h err %0d expected no response", resp_rdata, resp_err);
      end else begin
        logic [32:0] e;
        string nm;
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        chk({nm, "_rdata"}, resp_rdata, e[31:0]);
        chk({nm, "_err"}, {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  // Issues one request (called just after a rising edge) and waits for its response to appear.
  task automatic run(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input int exp_lat, input int exp_nacc);
    int k;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    sb_q.push_back({exp_e, exp_d});
    nm_q.push_back(nm);
    n_acc = 0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (MemRead || MemWrite) begin
        if (n_acc < 4) begin
          acc_addr[n_acc] = addr;
          acc_wd[n_acc]   = write_data;
          acc_be[n_acc]   = byte_enable;
        end
        n_acc++;
      end
      if (resp_valid) break;
      if (k > 20) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: got no resp_valid after %0d cycles expected it at cycle %0d", nm, k, exp_lat);
        break;
      end
    end
    chk({nm, "_latency"}, k, exp_lat);
    chk({nm, "_accesses"}, n_acc, exp_nacc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_byte_enable", {28'd0, byte_enable}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("sw_0", 1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    chk("sw_0_addr", acc_addr[0], 32'h0);
    chk("sw_0_be", {28'd0, acc_be[0]}, 32'hF);
    chk("sw_0_wd", acc_wd[0], 32'hDEADBEEF);
    run("lw_0", 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1);

    run("sb_a", 1'b1, 3'b000, 32'hA, 32'h000000AA, 32'h0, 1'b0, 2, 1);
    chk("sb_a_addr", acc_addr[0], 32'h8);
    chk("sb_a_be", {28'd0, acc_be[0]}, 32'h4);
    chk("sb_a_wd", acc_wd[0], 32'h00AA0000);
    run("lb_a", 1'b0, 3'b000, 32'hA, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1);
    run("lbu_a", 1'b0, 3'b100, 32'hA, 32'h0, 32'h000000AA, 1'b0, 2, 1);
    run("lh_1", 1'b0, 3'b001, 32'h1, 32'h0, 32'hFFFFADBE, 1'b0, 2, 1);
    chk("lh_1_be", {28'd0, acc_be[0]}, 32'h6);
    run("lhu_2", 1'b0, 3'b101, 32'h2, 32'h0, 32'h0000DEAD, 1'b0, 2, 1);

`ifdef LSU_MISALIGN_SPLIT_EN
    run("sw_6", 1'b1, 3'b010, 32'h6, 32'h11223344, 32'h0, 1'b0, 3, 2);
    chk("sw_6_addr0", acc_addr[0], 32'h4);
    chk("sw_6_be0", {28'd0, acc_be[0]}, 32'hC);
    chk("sw_6_wd0", acc_wd[0], 32'h33440000);
    chk("sw_6_addr1", acc_addr[1], 32'h8);
    chk("sw_6_be1", {28'd0, acc_be[1]}, 32'h3);
    chk("sw_6_wd1", acc_wd[1], 32'h00001122);
    run("lw_6", 1'b0, 3'b010, 32'h6, 32'h0, 32'h11223344, 1'b0, 3, 2);
`else
    run("sw_6", 1'b1, 3'b010, 32'h6, 32'h11223344, 32'h0, 1'b1, 1, 0);
    run("lw_6", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0);
`endif

    run("sb_fff", 1'b1, 3'b000, 32'hFFF, 32'h00000080, 32'h0, 1'b0, 2, 1);
    chk("sb_fff_addr", acc_addr[0], 32'hFFC);
    chk("sb_fff_be", {28'd0, acc_be[0]}, 32'h8);
    chk("sb_fff_wd", acc_wd[0], 32'h80000000);
    run("lb_fff", 1'b0, 3'b000, 32'hFFF, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1);
    run("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h80000000, 1'b0, 2, 1);
    run("lw_ffe", 1'b0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1'b1, 1, 0);
    run("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0);
    run("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    run("st_f3_100", 1'b1, 3'b100, 32'h0, 32'h12345678, 32'h0, 1'b1, 1, 0);

    resp_ready = 1'b0;
    run("lw_hold", 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_resp_rdata", resp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1;

    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h55555555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc0_memwrite_before", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_acc0_memwrite_after", {31'd0, MemWrite}, 32'd0);
    chk("rst_acc0_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("lw_10_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 2, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
